blk_tracker: RTL and testbench
==============================

// Module: blk_tracker
// PURPOSE
//  Tracks the raster position of the incoming video stream in the vin_clk_i domain and
//  produces the block coordinates consumed by the overlay and per-block statistics logic.
//  Divides the H_ACTIVE x V_ACTIVE active area into an HBLKS x VBLKS grid.
//  Sits directly after the video input sync stage; its outputs index per-block ROM/RAM.
// PARAMETERS
//  HBLKS     10    horizontal block count
//  VBLKS     10    vertical block count
//  H_ACTIVE  1920  active pixels per line
//  V_ACTIVE  1080  active lines per frame
//  VS_POL    1     vs_i active level (1 = active-high)
// PORTS
//  vin_clk_i    in   1                 pixel clock
//  rst_ni       in   1                 async reset, active-low
//  de_i         in   1                 data enable, one active pixel per cycle when high
//  vs_i         in   1                 vertical sync, polarity per VS_POL
//  ht_cur_o     out  $clog2(HBLKS)     horizontal block index of current pixel
//  vt_cur_o     out  $clog2(VBLKS)     vertical block index of current pixel
//  px_o         out  $clog2(H_ACTIVE)  pixel x within line
//  ln_o         out  $clog2(V_ACTIVE)  line y within frame
//  frame_start_o out 1                 1-cycle pulse on first active pixel of frame
//  geom_err_o   out  1                 sticky mismatch flag, cleared at next frame start
// BEHAVIOUR
//  Reset is asynchronous, active-low; clock is vin_clk_i.
//  Reset values: all outputs 0; internal counters 0; first_pix flag set.
//  BW = H_ACTIVE/HBLKS, BH = V_ACTIVE/VBLKS (integer division).
//   Last column/row absorbs any remainder.
//  Counters are registers holding the coordinates of the NEXT active pixel.
//   Outputs are driven straight from those registers, so on a de_i=1 cycle the outputs
//   describe that pixel: zero added latency relative to de_i.
//  Horizontal:
//   - Each de_i=1 cycle advances px and the in-block counter hx.
//   - When hx==BW-1 and ht<HBLKS-1: hx<=0, ht<=ht+1.
//   - Once ht==HBLKS-1, hx keeps counting and ht holds.
//  Line end (de_i 1->0):
//   - Check px against H_ACTIVE; if it differs, set geom_err_o.
//   - Reset px/hx/ht to 0 and advance ln and vy as above with BH/VBLKS.
//   - ln saturates at V_ACTIVE-1; a line beyond that sets geom_err_o.
//  Frame boundary (vs_i asserted edge per VS_POL):
//   - If ln != V_ACTIVE (lines counted), set geom_err_o.
//   - Clear all counters to 0 and set first_pix.
//   - Skip the error check on the first vs after reset.
//  frame_start_o:
//   - Asserts on the first de_i=1 cycle with first_pix set; first_pix then clears.
//   - Same cycle: geom_err_o clears, unless a new error is detected that cycle.
//  Simultaneous events:
//   - vs edge on the same cycle as a de fall: frame reset wins; the line check still runs.
//   - de_i high on the vs edge cycle: treat as first pixel of the new frame.
//  Reset mid-line: counters and flags return to reset values immediately.
//   - The first frame after reset is tracked from the next vs edge.
//   - Until that edge, lines are counted from 0 as if a frame had started.
//  Index widths: ht_cur_o never exceeds HBLKS-1; vt_cur_o never exceeds VBLKS-1.
// TESTING
//  1. H_ACTIVE=40, V_ACTIVE=20, 4x4 grid, one nominal frame:
//     - pixel 9 -> ht=0; pixel 10 -> ht=1; pixel 39 -> ht=3.
//     - line 5 -> vt=1; geom_err_o stays 0.
//  2. Non-divisible H_ACTIVE=42, HBLKS=4:
//     - pixels 30..41 -> ht=3; ht never reaches 4.
//  3. Line of 39 pixels mid-frame:
//     - geom_err_o=1 from that line end until the next frame_start_o.
//  4. vs edge coincident with de fall:
//     - counters 0 next cycle; frame_start_o pulses on the next de_i=1.
//  5. rst_ni low mid-line for 3 cycles:
//     - outputs 0 asynchronously; next de run starts at px=0, ht=0.
//  6. VS_POL=0, frame of 21 lines:
//     - geom_err_o set at vs edge; ln_o saturates at 19.

Source files
------------

// File: rtl/blk_tracker.sv
// Raster position tracker: turns de_i/vs_i into pixel, line and block coordinates with
// zero latency to de_i, plus a frame-start pulse and a sticky geometry-error flag.
module blk_tracker #(
    parameter int unsigned HBLKS    = 10,
    parameter int unsigned VBLKS    = 10,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic                        vin_clk_i,
    input  logic                        rst_ni,
    input  logic                        de_i,
    input  logic                        vs_i,
    output logic [$clog2(HBLKS)-1:0]    ht_cur_o,
    output logic [$clog2(VBLKS)-1:0]    vt_cur_o,
    output logic [$clog2(H_ACTIVE)-1:0] px_o,
    output logic [$clog2(V_ACTIVE)-1:0] ln_o,
    output logic                        frame_start_o,
    output logic                        geom_err_o
);

    localparam int unsigned HTW = $clog2(HBLKS);
    localparam int unsigned VTW = $clog2(VBLKS);
    localparam int unsigned PXW = $clog2(H_ACTIVE);
    localparam int unsigned LNW = $clog2(V_ACTIVE);
    localparam int unsigned BW  = H_ACTIVE / HBLKS;
    localparam int unsigned BH  = V_ACTIVE / VBLKS;
    localparam int unsigned HXW = (BW > 1) ? $clog2(BW) : 1;
    localparam int unsigned VYW = (BH > 1) ? $clog2(BH) : 1;

    // px/ln saturate at the last valid index; the *_full/*_over flags record
    // whether the exact active count was reached or exceeded.
    logic [HTW-1:0] ht_q, ht_d;
    logic [VTW-1:0] vt_q, vt_d;
    logic [PXW-1:0] px_q, px_d;
    logic [LNW-1:0] ln_q, ln_d;
    logic [HXW-1:0] hx_q, hx_d;
    logic [VYW-1:0] vy_q, vy_d;
    logic           px_full_q, px_full_d;
    logic           px_over_q, px_over_d;
    logic           ln_full_q, ln_full_d;
    logic           first_pix_q, first_pix_d;
    logic           seen_vs_q, seen_vs_d;
    logic           err_q, err_d;
    logic           de_q, vs_q;
    logic           vs_act, vs_edge, line_end, fs_c, new_err;

    assign vs_act   = VS_POL ? vs_i : ~vs_i;
    assign vs_edge  = vs_act & ~vs_q;
    assign line_end = de_q & ~de_i;
    assign fs_c     = rst_ni & de_i & (first_pix_q | vs_edge);

    // Next-state: line end, then frame boundary (overrides), then pixel advance.
    always_comb begin
        ht_d        = ht_q;
        vt_d        = vt_q;
        px_d        = px_q;
        ln_d        = ln_q;
        hx_d        = hx_q;
        vy_d        = vy_q;
        px_full_d   = px_full_q;
        px_over_d   = px_over_q;
        ln_full_d   = ln_full_q;
        first_pix_d = first_pix_q;
        seen_vs_d   = seen_vs_q;
        new_err     = 1'b0;

        if (line_end) begin
            if (!px_full_q || px_over_q || ln_full_q) new_err = 1'b1;
            px_d      = '0;
            hx_d      = '0;
            ht_d      = '0;
            px_full_d = 1'b0;
            px_over_d = 1'b0;
            if (!ln_full_q) begin
                if (ln_q == LNW'(V_ACTIVE - 1)) ln_full_d = 1'b1;
                else                            ln_d      = ln_q + LNW'(1);
            end
            if (vy_q == VYW'(BH - 1) && vt_q < VTW'(VBLKS - 1)) begin
                vy_d = '0;
                vt_d = vt_q + VTW'(1);
            end else begin
                vy_d = vy_q + VYW'(1);
            end
        end

        // ln_full_d already includes a line that ends on this same cycle
        if (vs_edge) begin
            if (seen_vs_q && !ln_full_d) new_err = 1'b1;
            seen_vs_d   = 1'b1;
            first_pix_d = 1'b1;
            px_d        = '0;
            hx_d        = '0;
            ht_d        = '0;
            ln_d        = '0;
            vy_d        = '0;
            vt_d        = '0;
            px_full_d   = 1'b0;
            px_over_d   = 1'b0;
            ln_full_d   = 1'b0;
        end

        if (de_i) begin
            first_pix_d = 1'b0;
            if (px_full_d)                       px_over_d = 1'b1;
            else if (px_d == PXW'(H_ACTIVE - 1)) px_full_d = 1'b1;
            else                                 px_d      = px_d + PXW'(1);
            if (hx_d == HXW'(BW - 1) && ht_d < HTW'(HBLKS - 1)) begin
                hx_d = '0;
                ht_d = ht_d + HTW'(1);
            end else begin
                hx_d = hx_d + HXW'(1);
            end
        end

        err_d = (fs_c ? 1'b0 : err_q) | new_err;
    end

    always_ff @(posedge vin_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ht_q        <= '0;
            vt_q        <= '0;
            px_q        <= '0;
            ln_q        <= '0;
            hx_q        <= '0;
            vy_q        <= '0;
            px_full_q   <= 1'b0;
            px_over_q   <= 1'b0;
            ln_full_q   <= 1'b0;
            first_pix_q <= 1'b1;
            seen_vs_q   <= 1'b0;
            err_q       <= 1'b0;
            de_q        <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            ht_q        <= ht_d;
            vt_q        <= vt_d;
            px_q        <= px_d;
            ln_q        <= ln_d;
            hx_q        <= hx_d;
            vy_q        <= vy_d;
            px_full_q   <= px_full_d;
            px_over_q   <= px_over_d;
            ln_full_q   <= ln_full_d;
            first_pix_q <= first_pix_d;
            seen_vs_q   <= seen_vs_d;
            err_q       <= err_d;
            de_q        <= de_i;
            vs_q        <= vs_act;
        end
    end

    assign ht_cur_o      = ht_q;
    assign vt_cur_o      = vt_q;
    assign px_o          = px_q;
    assign ln_o          = ln_q;
    assign frame_start_o = fs_c;
    assign geom_err_o    = err_q;

endmodule

// File: tb/tb_blk_tracker.sv
// Bench for blk_tracker: three configurations (40x20, 42x20, active-low vs) driven by
// one stream and compared every cycle against a pixel/line counting model.
module tb_blk_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic de    = 1'b0;
    logic vs    = 1'b0;
    logic vs_n  = 1'b1;

    logic [1:0] ht_a, ht_b, ht_c, vt_a, vt_b, vt_c;
    logic [5:0] px_a, px_b, px_c;
    logic [4:0] ln_a, ln_b, ln_c;
    logic       fs_a, fs_b, fs_c, err_a, err_b, err_c;

    blk_tracker #(.HBLKS(4), .VBLKS(4), .H_ACTIVE(40), .V_ACTIVE(20), .VS_POL(1'b1)) u_a (
        .vin_clk_i(clk), .rst_ni(rst_n), .de_i(de), .vs_i(vs),
        .ht_cur_o(ht_a), .vt_cur_o(vt_a), .px_o(px_a), .ln_o(ln_a),
        .frame_start_o(fs_a), .geom_err_o(err_a));

    blk_tracker #(.HBLKS(4), .VBLKS(4), .H_ACTIVE(42), .V_ACTIVE(20), .VS_POL(1'b1)) u_b (
        .vin_clk_i(clk), .rst_ni(rst_n), .de_i(de), .vs_i(vs),
        .ht_cur_o(ht_b), .vt_cur_o(vt_b), .px_o(px_b), .ln_o(ln_b),
        .frame_start_o(fs_b), .geom_err_o(err_b));

    blk_tracker #(.HBLKS(4), .VBLKS(4), .H_ACTIVE(40), .V_ACTIVE(20), .VS_POL(1'b0)) u_c (
        .vin_clk_i(clk), .rst_ni(rst_n), .de_i(de), .vs_i(vs_n),
        .ht_cur_o(ht_c), .vt_cur_o(vt_c), .px_o(px_c), .ln_o(ln_c),
        .frame_start_o(fs_c), .geom_err_o(err_c));

    // {ht[16:15], vt[14:13], px[12:7], ln[6:2], frame_start[1], geom_err[0]}
    logic [16:0] act [3];
    assign act[0] = {ht_a, vt_a, px_a, ln_a, fs_a, err_a};
    assign act[1] = {ht_b, vt_b, px_b, ln_b, fs_b, err_b};
    assign act[2] = {ht_c, vt_c, px_c, ln_c, fs_c, err_c};

    int errors = 0;
    int checks = 0;

    // Reference model: pixels seen in the current line, lines completed in the frame.
    int mh [3] = '{40, 42, 40};
    int m_pix [3];
    int m_lines [3];
    bit m_first [3];
    bit m_seen [3];
    bit m_err [3];
    bit m_pde [3];
    bit m_pvs [3];

    bit cap_en [2];
    int cap_ht [2][20][42];
    int cap_vt [2][20][42];

    typedef struct {
        int inst;
        int line;
        int pix;
        int exp_ht;
        int exp_vt;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pix[i] = 0; m_lines[i] = 0; m_first[i] = 1'b1; m_seen[i] = 1'b0;
            m_err[i] = 1'b0; m_pde[i] = 1'b0; m_pvs[i] = 1'b0;
        end
    endtask

    function automatic logic [16:0] model_out(input int i, input bit d, input bit v, input bit r);
        int bw, ht, vt, px, ln;
        bit fs;
        if (!r) return '0;
        bw = mh[i] / 4;
        ht = (m_pix[i] / bw > 3) ? 3 : m_pix[i] / bw;
        px = (m_pix[i] > mh[i] - 1) ? mh[i] - 1 : m_pix[i];
        ln = (m_lines[i] > 19) ? 19 : m_lines[i];
        vt = (m_lines[i] / 5 > 3) ? 3 : m_lines[i] / 5;
        fs = d && (m_first[i] || (v && !m_pvs[i]));
        return {2'(ht), 2'(vt), 6'(px), 5'(ln), fs, m_err[i]};
    endfunction

    task automatic model_step(input int i, input bit d, input bit v);
        bit ve, le, ne, fs;
        ve = v && !m_pvs[i];
        le = m_pde[i] && !d;
        ne = 1'b0;
        if (le) begin
            if (m_pix[i] != mh[i] || m_lines[i] >= 20) ne = 1'b1;
            m_lines[i]++;
            m_pix[i] = 0;
        end
        if (ve) begin
            if (m_seen[i] && m_lines[i] != 20) ne = 1'b1;
            m_seen[i] = 1'b1; m_pix[i] = 0; m_lines[i] = 0; m_first[i] = 1'b1;
        end
        fs = d && m_first[i];
        if (d) begin
            m_pix[i]++;
            m_first[i] = 1'b0;
        end
        if (fs) m_err[i] = 1'b0;
        if (ne) m_err[i] = 1'b1;
        m_pde[i] = d;
        m_pvs[i] = v;
    endtask

    // One clock: drive at the falling edge, compare 1 ns later, then advance the model.
    task automatic step3(input bit d, input bit v, input bit r);
        logic [16:0] exp;
        @(negedge clk);
        de = d; vs = v; vs_n = ~v; rst_n = r;
        #1;
        if (!r) model_reset();
        for (int i = 0; i < 3; i++) begin
            exp = model_out(i, d, v, r);
            checks++;
            if (act[i] !== exp) begin
                errors++;
                $display("FAIL cycle inst%0d at %0t: got %h expected %h", i, $time, act[i], exp);
            end
            if (i < 2 && cap_en[i] && d && r && m_lines[i] < 20 && m_pix[i] < 42) begin
                cap_ht[i][m_lines[i]][m_pix[i]] = int'(act[i][16:15]);
                cap_vt[i][m_lines[i]][m_pix[i]] = int'(act[i][14:13]);
            end
        end
        if (r) for (int i = 0; i < 3; i++) model_step(i, d, v);
    endtask

    task automatic step(input bit d, input bit v);
        step3(d, v, 1'b1);
    endtask

    task automatic line(input int len);
        repeat (len) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic rand_frame();
        int nl, base, len;
        bit vde, vfall;
        nl    = ($urandom % 4 == 0) ? (($urandom % 2 == 0) ? 19 : 21) : 20;
        base  = ($urandom % 2 == 0) ? 40 : 42;
        vde   = ($urandom % 3 == 0);
        vfall = ($urandom % 3 == 0);
        if (vde) begin
            step(1'b1, 1'b1);
        end else begin
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b1);
            repeat ($urandom_range(1, 2)) step(1'b0, 1'b0);
        end
        for (int l = 0; l < nl; l++) begin
            len = ($urandom % 8 == 0) ? int'($urandom_range(39, 43)) : base;
            for (int p = (l == 0 && vde) ? 1 : 0; p < len; p++) step(1'b1, 1'b0);
            if (l == nl - 1 && vfall) begin
                step(1'b0, 1'b1);
                step(1'b0, 1'b0);
            end else begin
                repeat ($urandom_range(1, 4)) step(1'b0, 1'b0);
            end
            if ($urandom % 60 == 0) begin
                step3(1'b0, 1'b0, 1'b0);
                step3(1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 0, 9, 0, 0};
        tbl[1] = '{0, 0, 10, 1, 0};
        tbl[2] = '{0, 0, 39, 3, 0};
        tbl[3] = '{0, 4, 0, 0, 0};
        tbl[4] = '{0, 5, 0, 0, 1};
        tbl[5] = '{0, 19, 39, 3, 3};
        tbl[6] = '{1, 0, 29, 2, 0};
        tbl[7] = '{1, 0, 30, 3, 0};
        tbl[8] = '{1, 0, 41, 3, 0};
        tbl[9] = '{1, 12, 41, 3, 2};
        for (int i = 0; i < 2; i++)
            for (int l = 0; l < 20; l++)
                for (int p = 0; p < 42; p++) begin
                    cap_ht[i][l][p] = -1;
                    cap_vt[i][l][p] = -1;
                end
        model_reset();

        // Reset state
        repeat (3) step3(1'b0, 1'b0, 1'b0);
        chk("reset_outputs_a", int'(act[0]), 0);
        repeat (2) step(1'b0, 1'b0);
        vs_pulse();

        // Nominal 40-pixel frame, captured for config A
        cap_en[0] = 1'b1;
        repeat (20) line(40);
        cap_en[0] = 1'b0;
        vs_pulse();
        chk("nominal_no_err_a", int'(err_a), 0);

        // Nominal 42-pixel frame, captured for config B
        cap_en[1] = 1'b1;
        repeat (20) line(42);
        cap_en[1] = 1'b0;
        vs_pulse();
        chk("nominal_no_err_b", int'(err_b), 0);

        // Short line mid-frame: error sticks until the next frame start
        repeat (7) line(40);
        line(39);
        chk("short_line_err_set", int'(err_a), 1);
        repeat (12) line(40);
        vs_pulse();
        chk("short_line_err_held", int'(err_a), 1);
        step(1'b1, 1'b0);
        chk("fs_after_short", int'(fs_a), 1);
        chk("err_on_fs_cycle", int'(err_a), 1);
        step(1'b1, 1'b0);
        chk("err_cleared", int'(err_a), 0);
        repeat (38) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // vs edge on the same cycle as the final de fall
        repeat (18) line(40);
        repeat (40) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("coinc_counters_zero", int'(act[0][16:2]), 0);
        chk("coinc_no_err", int'(err_a), 0);
        step(1'b0, 1'b0);
        chk("coinc_no_fs_idle", int'(fs_a), 0);
        step(1'b1, 1'b0);
        chk("coinc_fs_next_de", int'(fs_a), 1);

        // Asynchronous reset mid-line
        repeat (14) step(1'b1, 1'b0);
        chk("pre_reset_px", int'(px_a), 14);
        #1;
        rst_n = 1'b0;
        de = 1'b0;
        #1;
        chk("async_reset_a", int'(act[0]), 0);
        model_reset();
        repeat (3) step3(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("post_reset_px", int'(px_a), 0);
        chk("post_reset_ht", int'(ht_a), 0);
        chk("post_reset_fs", int'(fs_a), 1);
        repeat (39) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (19) line(40);
        vs_pulse();

        // 21-line frame seen by the active-low vs instance
        repeat (21) line(40);
        chk("long_frame_ln_sat_c", int'(ln_c), 19);
        vs_pulse();
        chk("long_frame_err_c", int'(err_c), 1);

        // Randomized frames
        repeat (12) rand_frame();
        vs_pulse();

        // Block-index vectors captured during the nominal frames
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("vec%0d_ht inst%0d l%0d p%0d", k, tbl[k].inst, tbl[k].line, tbl[k].pix),
                cap_ht[tbl[k].inst][tbl[k].line][tbl[k].pix], tbl[k].exp_ht);
            chk($sformatf("vec%0d_vt inst%0d l%0d p%0d", k, tbl[k].inst, tbl[k].line, tbl[k].pix),
                cap_vt[tbl[k].inst][tbl[k].line][tbl[k].pix], tbl[k].exp_vt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
